// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, FSM states and the result packer used by the
// reciprocal unit and its mantissa divider.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_t;

  function automatic logic [EXP_W+MAN_W:0] pack_fp(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    return {s, e, m};
  endfunction

endpackage

// File: rtl/finv_mant_div.sv
// Restoring divider producing floor(2^48 / D) one quotient bit per cycle,
// with a sticky flag from the final remainder.
module finv_mant_div
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [MAN_W:0]   d,
  output logic [MAN_W+1:0] q,
  output logic             sticky,
  output logic             done
);

  // Remainder stays below 2*D before the shift, so two spare bits suffice.
  localparam int REM_W = MAN_W + 3;

  logic [REM_W-1:0] rem_reg;
  logic [REM_W-1:0] rem_sel;
  logic [MAN_W:0]   d_reg;
  logic [MAN_W+1:0] q_reg;
  logic [4:0]       cnt_reg;
  logic             busy_reg;
  logic             bit_next;

  always_comb begin
    bit_next = (rem_reg >= {2'b00, d_reg});
    rem_sel  = bit_next ? (rem_reg - {2'b00, d_reg}) : rem_reg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_reg  <= '0;
      d_reg    <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= REM_W'(1) << (MAN_W + 1);
      d_reg    <= d;
      q_reg    <= '0;
      cnt_reg  <= 5'(MAN_W + 1);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rem_reg <= rem_sel << 1;
      q_reg   <= {q_reg[MAN_W:0], bit_next};
      if (cnt_reg == 5'd0) begin
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 5'd1;
      end
    end
  end

  assign q      = q_reg;
  assign sticky = |rem_reg;
  assign done   = busy_reg && (cnt_reg == 5'd0);

endmodule

// File: rtl/finv_iter.sv
// Multi-cycle binary32 reciprocal y = 1/x with valid/ready handshake, divide-by-zero
// flag on zero/denormal input and flush-to-zero of results below the normal range.
module finv_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  state_t state_reg, state_next;

  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             ovf_reg;
  logic [31:0]      y_reg;
  logic             s_reg;
  logic [EXP_W-1:0] e_reg;

  logic             x_s;
  logic [EXP_W-1:0] x_e;
  logic [MAN_W-1:0] x_m;
  logic             accept;
  logic             general;
  logic [31:0]      spec_y;
  logic             spec_ovf;

  logic [MAN_W+1:0] q;
  logic             sticky;
  logic             div_done;
  logic             inc;
  logic [MAN_W:0]   man_sum;
  logic             carry;
  logic [9:0]       exp_rnd;
  logic [31:0]      rnd_y;

  assign x_s     = x[31];
  assign x_e     = x[30:23];
  assign x_m     = x[22:0];
  assign accept  = in_valid && in_ready_reg;
  assign general = (x_e != '0) && (x_e != EXP_MAX) && (x_m != '0);

  always_comb begin
    spec_ovf = 1'b0;
    spec_y   = pack_fp(x_s, '0, '0);
    if (x_e == '0) begin
      spec_y   = pack_fp(x_s, EXP_MAX, '0);
      spec_ovf = 1'b1;
    end else if (x_e != EXP_MAX) begin
      // Power of two: exact result, exponent field 254-e (0 at e=254 flushes).
      spec_y = pack_fp(x_s, EXP_W'(2 * BIAS) - x_e, '0);
    end
  end

  finv_mant_div u_div (
    .clk    (clk),
    .rstn   (rstn),
    .start  (accept && general),
    .d      ({1'b1, x_m}),
    .q      (q),
    .sticky (sticky),
    .done   (div_done)
  );

  always_comb begin
    inc     = q[0] && (sticky || q[1]);
    man_sum = {1'b0, q[MAN_W:1]} + {{MAN_W{1'b0}}, inc};
    // Overflow past the hidden bit renormalises to mantissa 0, exponent + 1.
    carry   = q[MAN_W+1] && man_sum[MAN_W];
    exp_rnd = 10'(2 * BIAS - 1) - {2'b00, e_reg} + {9'd0, carry};
    if (exp_rnd[9] || (exp_rnd[8:0] == 9'd0)) begin
      rnd_y = pack_fp(s_reg, '0, '0);
    end else begin
      rnd_y = pack_fp(s_reg, exp_rnd[7:0], man_sum[MAN_W-1:0]);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = general ? DIV : DONE;
      DIV:     if (div_done) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      ovf_reg       <= 1'b0;
      s_reg         <= 1'b0;
      e_reg         <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_reg == DONE) && !(out_valid_reg && out_ready);
      if (accept) begin
        s_reg <= x_s;
        e_reg <= x_e;
        if (!general) begin
          y_reg   <= spec_y;
          ovf_reg <= spec_ovf;
        end
      end else if (state_reg == ROUND) begin
        y_reg   <= rnd_y;
        ovf_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_finv_iter.sv
// Directed and swept checks of finv_iter against a real-arithmetic reciprocal model.
module tb_finv_iter;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int last_acc_cyc = 0;
  logic [32:0] last_res = '0;

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic [31:0] x_q[$];

  finv_iter dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic timeout_fail(input string name, input int lim);
    n_checks++;
    $display("FAIL %s: got no event, required one within %0d cycles", name, lim);
  endtask

  // Round the exact reciprocal to nearest-even binary32, flushing subnormals.
  function automatic logic [32:0] model(input logic [31:0] xv);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] xd;
    logic [63:0] rb;
    real         r;
    int          ee;
    logic [23:0] kept;
    s = xv[31];
    e = xv[30:23];
    m = xv[22:0];
    if (e == 8'h00) return {1'b1, s, 8'hFF, 23'h0};
    if (e == 8'hFF) return {1'b0, s, 31'h0};
    xd   = {1'b0, 11'(e) + 11'd896, m, 29'h0};
    r    = 1.0 / $bitstoreal(xd);
    rb   = $realtobits(r);
    ee   = int'(rb[62:52]) - 1023 + 127;
    kept = {1'b0, rb[51:29]};
    if (rb[28] && ((|rb[27:0]) || kept[0])) kept = kept + 24'd1;
    if (kept[23]) begin
      ee   = ee + 1;
      kept = '0;
    end
    if (ee <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, ee[7:0], kept[22:0]};
  endfunction

  function automatic int lat_of(input logic [31:0] xv);
    if (xv[30:23] != 8'h00 && xv[30:23] != 8'hFF && xv[22:0] != 23'h0) return 27;
    return 1;
  endfunction

  // Compare process: checks every cycle the outputs are meaningful.
  initial begin
    bit rising;
    rising = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        x_q.delete();
        rising = 1'b1;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_out_valid: got out_valid=1, required 0 with nothing in flight");
          end else begin
            chk("result", {31'd0, ovf, y}, {31'd0, exp_q[0]});
            if (rising) chk("latency", cyc - acc_q[0] - 1, lat_q[0]);
            if (out_ready) begin
              $display("xact x=%h y=%h ovf=%b latency_ref=%0d", x_q[0], y, ovf, lat_q[0]);
              hs_cyc   = cyc;
              last_res = {ovf, y};
              void'(exp_q.pop_front());
              void'(lat_q.pop_front());
              void'(acc_q.pop_front());
              void'(x_q.pop_front());
            end
          end
        end
        rising = !(out_valid && !out_ready);
        if (in_valid && in_ready) begin
          exp_q.push_back(model(x));
          lat_q.push_back(lat_of(x));
          acc_q.push_back(cyc);
          x_q.push_back(x);
          last_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input logic [31:0] xv);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    x        = xv;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout_fail("accept", 200);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout_fail("wait_idle", 200);
        break;
      end
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        timeout_fail("wait_valid", 100);
        break;
      end
    end
  endtask

  logic [31:0] vx[12];
  logic [32:0] vy[12];

  initial begin
    int cnt;
    logic [31:0] rx;
    logic [7:0]  e8;
    vx = '{32'h40000000, 32'h40400000, 32'hC0400000, 32'h00000000,
           32'h80000001, 32'h7F000000, 32'h7E800001, 32'h7F800000,
           32'h40800000, 32'h3F800000, 32'h3FC00000, 32'hFF800000};
    vy = '{{1'b0, 32'h3F000000}, {1'b0, 32'h3EAAAAAB}, {1'b0, 32'hBEAAAAAB},
           {1'b1, 32'h7F800000}, {1'b1, 32'hFF800000}, {1'b0, 32'h00000000},
           {1'b0, 32'h00000000}, {1'b0, 32'h00000000}, {1'b0, 32'h3E800000},
           {1'b0, 32'h3F800000}, {1'b0, 32'h3F2AAAAB}, {1'b0, 32'h80000000}};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 12; i++) chk("model_pin", model(vx[i]), vy[i]);

    for (int i = 0; i < 12; i++) begin
      send(vx[i]);
      wait_idle();
      chk("direct_result", last_res, vy[i]);
    end

    // Backpressure: result held while a second operand waits.
    out_ready = 1'b0;
    send(32'h40400000);
    wait_valid();
    fork
      send(32'h40000000);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("hold_in_ready", in_ready, 0);
          chk("hold_out_valid", out_valid, 1);
          chk("hold_y", y, 32'h3EAAAAAB);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("accept_after_release", last_acc_cyc - hs_cyc, 1);
    wait_idle();
    chk("second_after_hold", last_res, {1'b0, 32'h3F000000});

    // Abort in the middle of the division.
    send(32'h40400000);
    repeat (12) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_result", cnt, 0);
    send(32'h40800000);
    wait_idle();
    chk("after_abort", last_res, {1'b0, 32'h3E800000});

    for (int i = 0; i < 40; i++) begin
      e8 = (i % 4 == 3) ? 8'(252 + (i % 3)) : 8'($urandom_range(1, 254));
      rx = {1'($urandom_range(0, 1)), e8, 23'($urandom)};
      send(rx);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1000000 time units");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
